// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues in-order memory requests and buffers
// returned instructions with their PC for decode, discarding wrong-path responses on redirect.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      fetch_pc, fetch_pc_nxt;
  logic [31:0]      resp_pc, resp_pc_nxt;
  logic [CNT_W-1:0] outstanding, outstanding_nxt;
  logic [CNT_W-1:0] drop, drop_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic             stale, stale_nxt;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic             redirect, grant, pop, push;
  logic [31:0]      target;
  logic [SUM_W-1:0] credit_sum;
  logic             if_valid_nxt, imem_req_nxt;
  logic [31:0]      imem_addr_nxt, pc4_nxt, inst_nxt;

  // Next-state: credit, redirect/drop accounting, queue pointers and registered outputs.
  always_comb begin
    redirect        = (pcsource == 2'b01) || (pcsource == 2'b10);
    target          = ((pcsource == 2'b10) ? jpc : bpc) & 32'hFFFF_FFFC;
    grant           = imem_req && imem_gnt;
    pop             = if_valid && id_ready;
    push            = imem_rvalid && (drop == '0) && !redirect;
    outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);

    drop_nxt     = drop + CNT_W'(grant && stale) - CNT_W'(imem_rvalid && (drop != '0));
    stale_nxt    = stale && !grant;
    fetch_pc_nxt = (grant && !stale) ? fetch_pc + 32'd4 : fetch_pc;
    resp_pc_nxt  = push ? resp_pc + 32'd4 : resp_pc;
    count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_nxt   = rd_ptr + PTR_W'(pop);
    wr_ptr_nxt   = wr_ptr + PTR_W'(push);

    // Every in-flight fetch becomes wrong-path; a still-pending request joins them once granted.
    if (redirect) begin
      drop_nxt     = outstanding_nxt;
      stale_nxt    = imem_req && !imem_gnt;
      fetch_pc_nxt = target;
      resp_pc_nxt  = target;
      count_nxt    = '0;
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
    end

    credit_sum = SUM_W'(outstanding_nxt) + SUM_W'(count_nxt);
    if (imem_req && !imem_gnt) begin
      imem_req_nxt  = 1'b1;
      imem_addr_nxt = imem_addr;
    end else begin
      imem_req_nxt  = credit_sum < SUM_W'(DEPTH);
      imem_addr_nxt = fetch_pc_nxt;
    end

    if_valid_nxt = (count_nxt != '0);
    pc4_nxt      = pc4;
    inst_nxt     = inst;
    if (if_valid_nxt) begin
      if (push && ((count - CNT_W'(pop)) == '0)) begin
        pc4_nxt  = resp_pc + 32'd4;
        inst_nxt = imem_rdata;
      end else begin
        pc4_nxt  = pc_q[rd_ptr_nxt] + 32'd4;
        inst_nxt = data_q[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      stale       <= 1'b0;
      if_valid    <= 1'b0;
      pc4         <= RESET_PC + 32'd4;
      inst        <= 32'd0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      count       <= count_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      stale       <= stale_nxt;
      if_valid    <= if_valid_nxt;
      pc4         <= pc4_nxt;
      inst        <= inst_nxt;
      imem_req    <= imem_req_nxt;
      imem_addr   <= imem_addr_nxt;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (clrn && push) begin
      pc_q[wr_ptr]   <= resp_pc;
      data_q[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: an in-order memory model plus a PC-stream
// reference that predicts what decode must see, with literal pins on key scenarios.
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] DOFS     = 32'h1000_0000;

  logic        clk, clrn, id_ready, if_valid, imem_req, imem_gnt, imem_rvalid;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, pc4, inst, imem_addr, imem_rdata;

  if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
    .id_ready(id_ready), .if_valid(if_valid), .pc4(pc4), .inst(inst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       memq[$];
  int          n_chk = 0, n_pass = 0;
  int unsigned cyc = 0;
  int          gnt_prob = 100, rv_prob = 100, ready_prob = 100, lat_min = 1, lat_max = 1;
  logic        clrn_set = 1'b0;

  // Reference state: the PC stream decode must receive and the fetch address stream.
  logic [31:0] exp_pc = RESET_PC, exp_fetch = RESET_PC, held_addr = '0, stale_addr = '0;
  bit          stale_pend = 0, hold_prev = 0, redir_prev = 0, reset_prev = 0;
  int          n_rel = 0, first_req_n = 0, first_valid_n = 0, pops_total = 0;
  logic [31:0] log_pc4[$], log_inst[$];
  bit          cap_armed = 0, cap_done = 0;
  logic [31:0] cap_pc4 = '0, cap_inst = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Compare process: evaluates the cycle's outputs and advances the model for the coming edge.
  always @(negedge clk) begin
    logic [31:0] tgt;
    if (!clrn) begin
      memq.delete();
      exp_pc = RESET_PC; exp_fetch = RESET_PC;
      stale_pend = 0; hold_prev = 0; redir_prev = 0; reset_prev = 1;
      n_rel = 0; first_req_n = 0; first_valid_n = 0;
      log_pc4.delete(); log_inst.delete();
    end else begin
      n_rel++;
      if (reset_prev) begin
        chk("reset_if_valid", if_valid, 0);
        chk("reset_imem_req", imem_req, 0);
        chk("reset_imem_addr", imem_addr, RESET_PC);
        chk("reset_pc4", pc4, RESET_PC + 32'd4);
        chk("reset_inst", inst, 0);
        reset_prev = 0;
      end
      if (first_req_n == 0 && imem_req) first_req_n = n_rel;
      if (first_valid_n == 0 && if_valid) first_valid_n = n_rel;
      if (redir_prev) chk("valid_after_redirect", if_valid, 0);
      if (hold_prev) begin
        chk("req_held", imem_req, 1);
        chk("addr_held", imem_addr, held_addr);
      end
      if (if_valid && id_ready) begin
        chk("pop_pc4", pc4, exp_pc + 32'd4);
        chk("pop_inst", inst, exp_pc + DOFS);
        if (log_pc4.size() < 3) begin log_pc4.push_back(pc4); log_inst.push_back(inst); end
        if (cap_armed) begin cap_pc4 = pc4; cap_inst = inst; cap_armed = 0; cap_done = 1; end
        exp_pc += 32'd4;
        pops_total++;
      end
      if (imem_rvalid && memq.size() > 0) void'(memq.pop_front());
      if (imem_req && imem_gnt) begin
        if (stale_pend) begin
          chk("stale_addr", imem_addr, stale_addr);
          stale_pend = 0;
        end else begin
          chk("fetch_addr", imem_addr, exp_fetch);
          exp_fetch += 32'd4;
        end
        memq.push_back('{addr: imem_addr, due: cyc + 32'($urandom_range(lat_max, lat_min))});
        chk("inflight_bound", 32'(memq.size() <= DEPTH), 1);
      end
      redir_prev = (pcsource == 2'b01) || (pcsource == 2'b10);
      if (redir_prev) begin
        tgt = (pcsource == 2'b10) ? jpc : bpc;
        tgt[1:0] = 2'b00;
        exp_pc = tgt; exp_fetch = tgt;
        if (imem_req && !imem_gnt) begin stale_pend = 1; stale_addr = imem_addr; end
        cap_armed = 1; cap_done = 0; cap_pc4 = '0; cap_inst = '0;
      end
      hold_prev = imem_req && !imem_gnt;
      held_addr = imem_addr;
    end
  end

  // One clock of stimulus, driven just after the rising edge.
  task automatic step(input logic [1:0] ps, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    cyc++;
    clrn     = clrn_set;
    pcsource = ps;
    bpc      = (ps == 2'b10) ? $urandom : tgt;
    jpc      = (ps == 2'b01) ? $urandom : tgt;
    id_ready = ($urandom_range(99, 0) < ready_prob);
    imem_gnt = ($urandom_range(99, 0) < gnt_prob);
    if (clrn_set && memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99, 0) < rv_prob) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memq[0].addr + DOFS;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic redirect_and_pin(input logic [1:0] ps, input logic [31:0] tgt,
                                  input logic [31:0] exp4, input int gnt_after, input string nm);
    step(ps, tgt);
    gnt_prob = gnt_after;
    step(2'b00, 32'h0);
    for (int i = 0; i < 60; i++) begin
      if (cap_done) break;
      step(2'b00, 32'h0);
    end
    chk({nm, "_pc4"}, cap_pc4, exp4);
    chk({nm, "_inst"}, cap_inst, exp4 - 32'd4 + DOFS);
  endtask

  initial begin
    clrn = 1'b0; pcsource = 2'b00; bpc = '0; jpc = '0; id_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset release with an always-granting 1-cycle memory.
    repeat (3) step(2'b00, 32'h0);
    clrn_set = 1'b1;
    repeat (20) step(2'b00, 32'h0);
    chk("first_req_cycle", first_req_n, 2);
    chk("first_valid_cycle", first_valid_n, 4);
    chk("log_count", 32'(log_pc4.size() >= 3), 1);
    if (log_pc4.size() >= 3) begin
      chk("first_pc4_0", log_pc4[0], 32'h4);
      chk("first_inst_0", log_inst[0], 32'h1000_0000);
      chk("first_pc4_1", log_pc4[1], 32'h8);
      chk("first_inst_1", log_inst[1], 32'h1000_0004);
      chk("first_pc4_2", log_pc4[2], 32'hC);
      chk("first_inst_2", log_inst[2], 32'h1000_0008);
    end

    // Back-pressure fills the queue and stops requests.
    ready_prob = 0;
    repeat (20) step(2'b00, 32'h0);
    chk("full_req_low", imem_req, 0);
    chk("full_valid", if_valid, 1);
    ready_prob = 100;
    repeat (20) step(2'b00, 32'h0);

    // Branch with several fetches in flight.
    lat_min = 3; lat_max = 3;
    repeat (10) step(2'b00, 32'h0);
    redirect_and_pin(2'b01, 32'h0000_0100, 32'h0000_0104, 100, "branch_inflight");

    // Redirect coinciding with a grant and a response.
    lat_min = 1; lat_max = 1;
    repeat (10) step(2'b00, 32'h0);
    redirect_and_pin(2'b01, 32'h0000_0400, 32'h0000_0404, 100, "redir_rv_gnt");

    // pcsource=11 is sequential; then a jump and an unaligned target near the top of memory.
    repeat (8) step(2'b11, 32'h0000_0800);
    redirect_and_pin(2'b10, 32'h0000_2000, 32'h0000_2004, 100, "jump");
    redirect_and_pin(2'b10, 32'hFFFF_FFFA, 32'hFFFF_FFFC, 100, "wrap");
    repeat (10) step(2'b00, 32'h0);

    // Grant stalled across a redirect; then a mid-stream reset.
    lat_min = 1; lat_max = 2;
    gnt_prob = 0;
    repeat (5) step(2'b00, 32'h0);
    redirect_and_pin(2'b01, 32'h0000_0300, 32'h0000_0304, 100, "gnt_stall");
    ready_prob = 50;
    repeat (6) step(2'b00, 32'h0);
    clrn_set = 1'b0;
    step(2'b00, 32'h0);
    clrn_set = 1'b1;
    repeat (10) step(2'b00, 32'h0);

    // Randomized traffic with occasional redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] ps;
      if (i % 200 == 0) begin
        gnt_prob   = $urandom_range(100, 20);
        rv_prob    = $urandom_range(100, 20);
        ready_prob = $urandom_range(100, 10);
        lat_min    = 1;
        lat_max    = $urandom_range(5, 1);
      end
      clrn_set = ($urandom_range(999, 0) != 0);
      r = $urandom_range(99, 0);
      ps = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r < 11) ? 2'b11 : 2'b00;
      step(ps, $urandom);
    end
    clrn_set = 1'b1;
    repeat (5) step(2'b00, 32'h0);
    chk("liveness", 32'(pops_total > 500), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
